// File: rtl/store_buffer.sv
// Posted-write buffer in front of the byte-laned data RAM. Stores queue in a
// small FIFO and drain whenever the RAM port is idle. Loads bypass the queue
// unless they hit a word that still has a pending store.
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_sel,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic [31:0] rd_data,
    input  logic        hold,
    output logic        empty,
    output logic        ram_ce,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [3:0]  ram_sel,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);
    localparam int PW = $clog2(DEPTH);

    logic [29:0]   e_addr  [DEPTH];
    logic [3:0]    e_sel   [DEPTH];
    logic [31:0]   e_wdata [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW:0]   count;

    logic [DEPTH-1:0] live;
    logic [PW-1:0]    off;
    logic             hazard;
    logic             load_acc;
    logic             drain;
    logic             store_acc;

    // An entry is live when its distance from head is below count; pointer
    // equality alone cannot tell full from empty.
    always_comb begin
        live   = '0;
        off    = '0;
        hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            off     = PW'(i) - head;
            live[i] = ({1'b0, off} < count);
            if (live[i] && (e_addr[i] == req_addr[31:2]))
                hazard = 1'b1;
        end
    end

    assign load_acc  = req_valid & ~req_we & ~hold & ~hazard;
    assign drain     = (count != '0) & ~hold & ~load_acc;
    assign store_acc = req_valid & req_we & ((count < (PW+1)'(DEPTH)) | drain);
    assign req_ready = load_acc | store_acc;
    assign rd_data   = load_acc ? ram_rdata : 32'h0;
    assign empty     = (count == '0);

    always_comb begin
        ram_ce    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = 32'h0;
        ram_sel   = 4'h0;
        ram_wdata = 32'h0;
        if (load_acc) begin
            ram_ce   = 1'b1;
            ram_addr = req_addr;
            ram_sel  = 4'hf;
        end else if (drain) begin
            ram_ce    = 1'b1;
            ram_we    = 1'b1;
            ram_addr  = {e_addr[head], 2'b00};
            ram_sel   = e_sel[head];
            ram_wdata = e_wdata[head];
        end
    end

    // Entry payload needs no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (store_acc) begin
            e_addr[tail]  <= req_addr[31:2];
            e_sel[tail]   <= req_sel;
            e_wdata[tail] <= req_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (drain)
                head <= head + 1'b1;
            if (store_acc)
                tail <= tail + 1'b1;
            case ({store_acc, drain})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule
